// File: rtl/shake_arb_pkg.sv
// Shared definitions for the SHAKE core arbiter: FSM state encoding,
// the default word width and the CLOG2 helper macro (minimum result 1).

`ifndef SHAKE_ARB_CLOG2_DEFINED
`define SHAKE_ARB_CLOG2_DEFINED
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package shake_arb_pkg;

    // Arbiter session states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // Default SHAKE din/dout word width.
    localparam int DW_DEFAULT = 32;

endpackage : shake_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first asserted
// request at or after ptr, wrapping modulo N. Usable by any arbiter that
// shares one resource between N requesters.

module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Candidate index for search offset off, wrapped into 0..N-1.
    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % N;
    endfunction

    // Scan from ptr upwards and keep the first requester found.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[wrap_idx(int'(ptr), k)]) begin
                found = 1'b1;
                idx   = IDX_W'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule : rr_pick

// File: rtl/shake_arbiter.sv
// Round-robin arbiter sharing one keccak_top SHAKE core between N_REQ
// requesters. A requester owns the core for a whole session, from its first
// din_valid to its force_done pulse; data is muxed combinationally so the
// owner sees the core with no added latency. After each session one RELEASE
// cycle drives all core inputs low so the core can clear.
// Optional build macro: SHAKE_ARB_PROFILE_EN adds per-session word counters
// and a completed-session counter.

module shake_arbiter
    import shake_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DW    = DW_DEFAULT,
    parameter int IDX_W = `CLOG2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    // Requester side
    input  logic [N_REQ-1:0]    req_din_valid,
    input  logic [N_REQ*DW-1:0] req_din,
    output logic [N_REQ-1:0]    req_din_ready,
    output logic [N_REQ-1:0]    req_dout_valid,
    output logic [DW-1:0]       req_dout,
    input  logic [N_REQ-1:0]    req_dout_ready,
    input  logic [N_REQ-1:0]    req_force_done,
    // Status
    output logic [N_REQ-1:0]    grant,
    output logic                busy,
    // Core side
    output logic                shake_din_valid,
    input  logic                shake_din_ready,
    output logic [DW-1:0]       shake_din,
    input  logic                shake_dout_valid,
    output logic                shake_dout_ready,
    input  logic [DW-1:0]       shake_dout,
    output logic                shake_force_done
`ifdef SHAKE_ARB_PROFILE_EN
    ,
    output logic [31:0]         prof_in_words,
    output logic [31:0]         prof_out_words,
    output logic [15:0]         prof_sessions
`endif
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_inc;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_din_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The output word is broadcast; only the valids are gated per owner.
    assign req_dout = shake_dout;

    // Next round-robin start: the requester after the current owner.
    assign owner_inc = (int'(owner_q) >= N_REQ - 1) ? '0 : owner_q + 1'b1;

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state logic and the owner pass-through mux.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        rr_ptr_d         = rr_ptr_q;
        grant            = '0;
        busy             = 1'b0;
        req_din_ready    = '0;
        req_dout_valid   = '0;
        shake_din_valid  = 1'b0;
        shake_din        = '0;
        shake_dout_ready = 1'b0;
        shake_force_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                busy             = 1'b1;
                grant[owner_q]   = 1'b1;
                // force_done wins over a word offered in the same cycle:
                // the word is neither forwarded nor acknowledged.
                shake_din_valid  = req_din_valid[owner_q] & ~req_force_done[owner_q];
                shake_din        = req_din[int'(owner_q)*DW +: DW];
                req_din_ready[owner_q]  = shake_din_ready & ~req_force_done[owner_q];
                req_dout_valid[owner_q] = shake_dout_valid;
                shake_dout_ready = req_dout_ready[owner_q];
                shake_force_done = req_force_done[owner_q];
                if (req_force_done[owner_q]) begin
                    rr_ptr_d = owner_inc;
                    state_d  = RELEASE;
                end
            end

            RELEASE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SHAKE_ARB_PROFILE_EN
    logic [31:0] in_words_q;
    logic [31:0] out_words_q;
    logic [15:0] sessions_q;
    logic        session_start;

    assign session_start = (state_q != GRANT) && (state_d == GRANT);

    // Per-session word counters and the completed-session counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_words_q  <= '0;
            out_words_q <= '0;
            sessions_q  <= '0;
        end else begin
            if (session_start) begin
                in_words_q  <= '0;
                out_words_q <= '0;
            end else begin
                if (shake_din_valid && shake_din_ready) begin
                    in_words_q <= in_words_q + 32'd1;
                end
                if (shake_dout_valid && shake_dout_ready) begin
                    out_words_q <= out_words_q + 32'd1;
                end
            end
            if (shake_force_done) begin
                sessions_q <= sessions_q + 16'd1;
            end
        end
    end

    assign prof_in_words  = in_words_q;
    assign prof_out_words = out_words_q;
    assign prof_sessions  = sessions_q;
`endif

endmodule : shake_arbiter
